// File: rtl/mem_req_pkg.sv
// Shared types for the memory request master.
//   state_t    : request sequencer state (idle / read burst in progress)
//   rsp_beat_t : one buffered read beat (data word plus end-of-burst tag)
package mem_req_pkg;

    // Width of a buffered response word; mem_req_master's RAM_WIDTH must equal this.
    localparam int unsigned RamWidth = 32;

    typedef enum logic {
        StIdle,
        StRead
    } state_t;

    typedef struct packed {
        logic [RamWidth-1:0] data;
        logic                last;
    } rsp_beat_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous response FIFO holding read beats in order.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset (empties the FIFO)
//   push_i, wdata_i    write a beat (ignored when full without a simultaneous pop)
//   pop_i              remove the head beat (ignored when empty)
//   rdata_o            head beat; stable until popped
//   count_o            number of stored beats
//   full_o, empty_o    occupancy flags
module mem_rsp_fifo
    import mem_req_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  rsp_beat_t                    wdata_i,
    input  logic                         pop_i,
    output rsp_beat_t                    rdata_o,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    rsp_beat_t       mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted in.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mem_req_master.sv
// Initiator for a single-port synchronous data memory (1-cycle read latency).
// Accepts client requests (single-beat writes, read bursts of req_len+1 beats),
// issues read beats with incrementing (wrapping) addresses under a credit scheme,
// and returns read data through a small response FIFO with valid/ready.
// Ports:
//   clock, reset                      clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake; ready only while idle
//   req_write/req_addr/req_len/req_wdata  request fields
//   rsp_valid/rsp_ready/rsp_data/rsp_last response beat stream
//   busy                              burst active, read in flight, or FIFO non-empty
//   mem_enable/mem_write_enable/mem_address/mem_wdata/mem_rdata  memory port
module mem_req_master
    import mem_req_pkg::*;
#(
    parameter int unsigned RAM_WIDTH     = RamWidth,
    parameter int unsigned RAM_ADDR_BITS = 9,
    parameter int unsigned LEN_BITS      = 4,
    parameter int unsigned RSP_DEPTH     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [RAM_ADDR_BITS-1:0] req_addr,
    input  logic [LEN_BITS-1:0]      req_len,
    input  logic [RAM_WIDTH-1:0]     req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RAM_WIDTH-1:0]     rsp_data,
    output logic                     rsp_last,
    output logic                     busy,
    output logic                     mem_enable,
    output logic                     mem_write_enable,
    output logic [RAM_ADDR_BITS-1:0] mem_address,
    output logic [RAM_WIDTH-1:0]     mem_wdata,
    input  logic [RAM_WIDTH-1:0]     mem_rdata
);

    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]      rem_q, rem_d;
    logic                     inflight_q, inflight_d;
    logic                     inflight_last_q, inflight_last_d;

    logic                     pop, issue, credit_ok, write_hs, read_hs;
    logic [CntW-1:0]          fifo_count;
    logic                     fifo_full, fifo_empty;
    rsp_beat_t                fifo_rdata, push_beat;

    // Gated by reset so every output reads 0 while reset is held.
    assign req_ready = (state_q == StIdle) & ~reset;
    assign write_hs  = req_ready & req_valid & req_write;
    assign read_hs   = req_ready & req_valid & ~req_write;
    assign pop       = rsp_valid & rsp_ready;

    // A beat may only be issued if the FIFO is sure to have room when its data lands.
    assign credit_ok = (int'(inflight_q) + int'(fifo_count) - int'(pop)) < int'(RSP_DEPTH);
    assign issue     = (state_q == StRead) & credit_ok;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = issue;
        inflight_last_d = issue & (rem_q == '0);
        unique case (state_q)
            StIdle: begin
                if (read_hs) begin
                    addr_d  = req_addr;
                    rem_d   = req_len;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (issue) begin
                    addr_d = addr_q + RAM_ADDR_BITS'(1);
                    if (rem_q == '0) state_d = StIdle;
                    else             rem_d   = rem_q - LEN_BITS'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        mem_enable       = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_wdata        = '0;
        if (write_hs) begin
            mem_enable       = 1'b1;
            mem_write_enable = 1'b1;
            mem_address      = req_addr;
            mem_wdata        = req_wdata;
        end else if (issue) begin
            mem_enable  = 1'b1;
            mem_address = addr_q;
        end
        busy      = (state_q == StRead) | inflight_q | ~fifo_empty;
        rsp_valid = ~fifo_empty;
        rsp_data  = fifo_empty ? '0 : fifo_rdata.data;
        rsp_last  = ~fifo_empty & fifo_rdata.last;
    end

    assign push_beat = '{data: mem_rdata, last: inflight_last_q};

    mem_rsp_fifo #(
        .Depth (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (inflight_q),
        .wdata_i (push_beat),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The credit rule must make overflow impossible.
    a_no_overflow : assert property (@(posedge clock) disable iff (reset)
        (inflight_q && !pop) |-> !fifo_full);

endmodule

// File: tb/tb_mem_req_master.sv
module tb_mem_req_master;

    localparam int W  = 32;
    localparam int AB = 9;
    localparam int LB = 4;
    localparam int D  = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AB-1:0] req_addr = '0;
    logic [LB-1:0] req_len = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_last, busy;
    logic [W-1:0]  rsp_data;
    logic          mem_enable, mem_write_enable;
    logic [AB-1:0] mem_address;
    logic [W-1:0]  mem_wdata, mem_rdata;

    mem_req_master #(
        .RAM_WIDTH     (W),
        .RAM_ADDR_BITS (AB),
        .LEN_BITS      (LB),
        .RSP_DEPTH     (D)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_last         (rsp_last),
        .busy             (busy),
        .mem_enable       (mem_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory the DUT talks to: synchronous, one-cycle read latency.
    logic [W-1:0] tb_mem [1<<AB];
    always @(posedge clock) begin
        if (mem_enable) begin
            if (mem_write_enable) tb_mem[mem_address] <= mem_wdata;
            else                  mem_rdata <= tb_mem[mem_address];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pend_*: beats accepted but not yet sent to memory; iss_*: issued, not yet consumed.
    logic [W-1:0]  ref_mem [1<<AB];
    logic [AB-1:0] pend_addr[$];
    logic [W-1:0]  pend_data[$];
    bit            pend_last[$];
    logic [W-1:0]  iss_data[$];
    bit            iss_last[$];
    int            iss_avail[$];
    // Observation logs used by the directed checks.
    logic [AB-1:0] obs_addr[$];
    int            obs_icyc[$];
    logic [W-1:0]  obs_data[$];
    bit            obs_last[$];

    bit            e_ready, e_valid, e_pop, e_wr, e_rd, e_issue;
    logic [AB-1:0] a_tmp;

    always @(negedge clock) begin
        if (reset) begin
            pend_addr.delete(); pend_data.delete(); pend_last.delete();
            iss_data.delete();  iss_last.delete();  iss_avail.delete();
        end else begin
            e_ready = (pend_addr.size() == 0);
            e_valid = (iss_data.size() > 0) && (iss_avail[0] <= cyc);
            e_pop   = e_valid && rsp_ready;
            e_wr    = e_ready && req_valid && req_write;
            e_rd    = e_ready && req_valid && !req_write;
            e_issue = (pend_addr.size() > 0) && ((iss_data.size() - (e_pop ? 1 : 0)) < D);

            chk("req_ready", req_ready, e_ready);
            chk("rsp_valid", rsp_valid, e_valid);
            if (e_valid && rsp_valid) begin
                chk("rsp_data", rsp_data, iss_data[0]);
                chk("rsp_last", rsp_last, iss_last[0]);
            end
            chk("busy", busy, (pend_addr.size() > 0) || (iss_data.size() > 0));
            chk("mem_enable", mem_enable, e_wr || e_issue);
            if (e_wr) begin
                chk("wr_we", mem_write_enable, 1'b1);
                chk("wr_addr", mem_address, req_addr);
                chk("wr_data", mem_wdata, req_wdata);
            end else if (e_issue) begin
                chk("rd_we", mem_write_enable, 1'b0);
                chk("rd_addr", mem_address, pend_addr[0]);
            end

            if (mem_enable && !mem_write_enable) begin
                obs_addr.push_back(mem_address);
                obs_icyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                obs_data.push_back(rsp_data);
                obs_last.push_back(rsp_last);
            end

            if (e_pop) begin
                void'(iss_data.pop_front());
                void'(iss_last.pop_front());
                void'(iss_avail.pop_front());
            end
            if (e_issue) begin
                iss_data.push_back(pend_data.pop_front());
                iss_last.push_back(pend_last.pop_front());
                iss_avail.push_back(cyc + 2);  // data returns next cycle, visible one later
                void'(pend_addr.pop_front());
            end
            if (e_wr) ref_mem[req_addr] = req_wdata;
            if (e_rd) begin
                for (int i = 0; i <= int'(req_len); i++) begin
                    a_tmp = req_addr + AB'(i);
                    pend_addr.push_back(a_tmp);
                    pend_data.push_back(ref_mem[a_tmp]);
                    pend_last.push_back(i == int'(req_len));
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    bit rand_mode = 1'b0;
    always @(posedge clock) begin
        if (rand_mode) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_icyc.delete(); obs_data.delete(); obs_last.delete();
    endtask

    task automatic do_req(input bit w, input logic [AB-1:0] a, input logic [LB-1:0] l,
                          input logic [W-1:0] d, output int acc);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            #2;
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("req_accept_timeout", 0, 1);
        sync();
        req_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n, input string name);
        for (int i = 0; i < 300; i++) begin
            if (obs_data.size() >= n) break;
            @(negedge clock);
            #2;
        end
        if (obs_data.size() < n) chk(name, obs_data.size(), n);
        sync();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int acc, acc2, t0;
    bit w;
    logic [AB-1:0] ra;
    logic [LB-1:0] rl;
    logic [W-1:0]  rd;

    initial begin
        for (int i = 0; i < (1 << AB); i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        mem_rdata = '0;

        // Reset state
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_enable", mem_enable, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1'b1);

        // Write then single-beat read back, with latency
        rsp_ready = 1'b1;
        do_req(1'b1, 9'h010, 4'd0, 32'hDEADBEEF, acc);
        clear_obs();
        do_req(1'b0, 9'h010, 4'd0, 32'h0, acc);
        t0 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #2;
            if (rsp_valid) begin
                t0 = cyc;
                break;
            end
        end
        chk("t1_latency_edges", t0 - acc, 3);
        wait_pops(1, "t1_timeout");
        chk("t1_data", obs_data[0], 32'hDEADBEEF);
        chk("t1_last", obs_last[0], 1'b1);

        // Preload and stream a 4-beat burst
        for (int i = 0; i < 4; i++) do_req(1'b1, AB'(9'h020 + i), 4'd0, W'(i + 1), acc);
        clear_obs();
        do_req(1'b0, 9'h020, 4'd3, 32'h0, acc);
        wait_pops(4, "t2_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("t2_data", obs_data[i], W'(i + 1));
            chk("t2_last", obs_last[i], i == 3);
        end
        chk("t2_issue_span", obs_icyc[3] - obs_icyc[0], 3);

        // Same burst under backpressure
        rsp_ready = 1'b0;
        clear_obs();
        do_req(1'b0, 9'h020, 4'd3, 32'h0, acc);
        repeat (10) sync();
        chk("t3_stalled_issues", obs_addr.size(), D);
        rsp_ready = 1'b1;
        wait_pops(4, "t3_timeout");
        for (int i = 0; i < 4; i++) chk("t3_data", obs_data[i], W'(i + 1));

        // Address wrap
        do_req(1'b1, 9'h1FF, 4'd0, 32'h000000AA, acc);
        do_req(1'b1, 9'h000, 4'd0, 32'h000000BB, acc);
        clear_obs();
        do_req(1'b0, 9'h1FF, 4'd1, 32'h0, acc);
        wait_pops(2, "t4_timeout");
        chk("t4_addr0", obs_addr[0], 9'h1FF);
        chk("t4_addr1", obs_addr[1], 9'h000);
        chk("t4_data0", obs_data[0], 32'hAA);
        chk("t4_data1", obs_data[1], 32'hBB);
        chk("t4_last", {obs_last[0], obs_last[1]}, 2'b01);

        // Reset in the middle of a long burst
        clear_obs();
        do_req(1'b0, 9'h000, 4'd7, 32'h0, acc);
        t0 = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            #2;
            if (obs_data.size() == 1 && rsp_valid) begin
                t0 = cyc;
                break;
            end
        end
        if (t0 < 0) chk("t5_second_beat_timeout", 0, 1);
        reset = 1'b1;
        #1;
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_mem_enable", mem_enable, 1'b0);
        chk("t5_req_ready", req_ready, 1'b0);
        sync();
        sync();
        reset = 1'b0;
        do_req(1'b1, 9'h030, 4'd0, 32'h00000055, acc);
        clear_obs();
        do_req(1'b0, 9'h030, 4'd0, 32'h0, acc);
        wait_pops(1, "t5_after_timeout");
        chk("t5_after_data", obs_data[0], 32'h55);

        // Request held while a burst runs
        clear_obs();
        do_req(1'b0, 9'h020, 4'd3, 32'h0, acc);
        do_req(1'b1, 9'h040, 4'd0, 32'h00000077, acc2);
        chk("t6_issues_before_accept", obs_addr.size(), 4);
        chk("t6_accept_gap", acc2 - acc, 5);
        wait_pops(4, "t6_timeout");

        // Randomized traffic against the model
        rand_mode = 1'b1;
        for (int n = 0; n < 250; n++) begin
            w  = ($urandom_range(0, 3) == 0);
            ra = AB'($urandom);
            rl = LB'($urandom);
            rd = $urandom;
            do_req(w, ra, rl, rd, acc);
            repeat ($urandom_range(0, 2)) sync();
        end
        rand_mode = 1'b0;
        sync();
        rsp_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (!busy) break;
            sync();
        end
        chk("drain_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
